// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and lane-count helpers for the bus unpacker.
`default_nettype none

package conv_pkg;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} unpack_state_t;

  function automatic int lanes_of(input int io_w, input int word_w);
    return io_w / word_w;
  endfunction

  function automatic int clamp_lanes(input int lanes, input int max_lanes);
    return (lanes > max_lanes) ? max_lanes : lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_lane_mux.sv
// conv_lane_mux: combinational LANES:1 word select from a packed beat by lane index.
`default_nettype none

module conv_lane_mux
  import conv_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int LANES      = 3,
  parameter int IDX_W      = 2
) (
  input  logic [LANES*WORD_WIDTH-1:0] i_beat,
  input  logic [IDX_W-1:0]            i_idx,
  output logic [WORD_WIDTH-1:0]       o_word
);

  always_comb begin
    o_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_idx == IDX_W'(k)) o_word = i_beat[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_bus_unpacker.sv
// conv_bus_unpacker: splits wide bus beats into words, lane 0 first, with partial-beat support.
// Optional frame marker tracking enabled by defining CONV_UNPACK_LAST_EN.
`default_nettype none

module conv_bus_unpacker
  import conv_pkg::*;
#(
  parameter  int IO_DATA_WIDTH = 48,
  parameter  int WORD_WIDTH    = 16,
  localparam int LANES         = lanes_of(IO_DATA_WIDTH, WORD_WIDTH),
  localparam int CNT_W         = $clog2(LANES + 1)
) (
  input  logic                     clk,
  input  logic                     srst_in,
  input  logic                     flush_in,
  input  logic [IO_DATA_WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]         in_lanes,
  input  logic                     in_valid,
  output logic                     in_ready,
`ifdef CONV_UNPACK_LAST_EN
  input  logic                     in_last,
  output logic                     out_last,
`endif
  output logic [WORD_WIDTH-1:0]    out_word,
  output logic                     out_valid,
  input  logic                     out_ready
);

  if (IO_DATA_WIDTH % WORD_WIDTH != 0) begin : g_width_check
    $error("IO_DATA_WIDTH must be a multiple of WORD_WIDTH");
  end

  unpack_state_t            r_state;
  unpack_state_t            w_state_nxt;
  logic [IO_DATA_WIDTH-1:0] r_beat;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_idx;
  logic [CNT_W-1:0]         w_eff;
  logic                     w_final_lane;
  logic                     w_consume;
  logic                     w_final;
  logic                     w_accept;
  logic                     w_load;

  assign w_eff        = CNT_W'(clamp_lanes(int'(in_lanes), LANES));
  assign w_final_lane = (r_idx == r_cnt - 1'b1);
  assign w_consume    = out_valid && out_ready;
  assign w_final      = w_consume && w_final_lane;
  assign w_accept     = in_valid && in_ready;
  // Zero-lane beats are accepted but never loaded.
  assign w_load       = w_accept && (w_eff != '0);

  always_ff @(posedge clk) begin
    if (srst_in) r_state <= EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_in)     w_state_nxt = EMPTY;
    else if (w_load)  w_state_nxt = HOLD;
    else if (w_final) w_state_nxt = EMPTY;
  end

  always_comb begin
    out_valid = (r_state == HOLD);
    in_ready  = !srst_in && !flush_in && ((r_state == EMPTY) || w_final);
  end

  always_ff @(posedge clk) begin
    if (srst_in) begin
      r_beat <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
    end else if (flush_in) begin
      r_idx <= '0;
    end else if (w_load) begin
      r_beat <= in_data;
      r_cnt  <= w_eff;
      r_idx  <= '0;
    end else if (w_final) begin
      r_idx <= '0;
    end else if (w_consume) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  conv_lane_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .LANES      (LANES),
    .IDX_W      (CNT_W)
  ) u_lane_mux (
    .i_beat (r_beat),
    .i_idx  (r_idx),
    .o_word (out_word)
  );

`ifdef CONV_UNPACK_LAST_EN
  logic r_last;
  logic r_pend;
  logic w_zero_last;

  // An empty marker beat either tags the word being finished now or waits for the next real beat.
  assign w_zero_last = w_accept && (w_eff == '0) && in_last;
  assign out_last    = out_valid && w_final_lane && (r_last || w_zero_last);

  always_ff @(posedge clk) begin
    if (srst_in || flush_in) begin
      r_last <= 1'b0;
      r_pend <= 1'b0;
    end else if (w_load) begin
      r_last <= in_last || r_pend;
      r_pend <= 1'b0;
    end else if (w_zero_last && !w_final) begin
      r_pend <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_bus_unpacker.sv
// tb_conv_bus_unpacker: table-driven cycle vectors for the default build plus a clamp sequence on a 5-lane instance.
`default_nettype none

module tb_conv_bus_unpacker;

  logic        clk;
  logic        srst_in, flush_in, in_valid, in_ready, out_valid, out_ready, in_last, out_last;
  logic [47:0] in_data;
  logic [1:0]  in_lanes;
  logic [15:0] out_word;

  logic        flush5, in_valid5, in_ready5, out_valid5, out_ready5, in_last5, out_last5;
  logic [79:0] in_data5;
  logic [2:0]  in_lanes5;
  logic [15:0] out_word5;

  int n_checks = 0;
  int n_errors = 0;

  conv_bus_unpacker #(.IO_DATA_WIDTH(48), .WORD_WIDTH(16)) u_dut (
    .clk       (clk),
    .srst_in   (srst_in),
    .flush_in  (flush_in),
    .in_data   (in_data),
    .in_lanes  (in_lanes),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef CONV_UNPACK_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  conv_bus_unpacker #(.IO_DATA_WIDTH(80), .WORD_WIDTH(16)) u_dut5 (
    .clk       (clk),
    .srst_in   (srst_in),
    .flush_in  (flush5),
    .in_data   (in_data5),
    .in_lanes  (in_lanes5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
`ifdef CONV_UNPACK_LAST_EN
    .in_last   (in_last5),
    .out_last  (out_last5),
`endif
    .out_word  (out_word5),
    .out_valid (out_valid5),
    .out_ready (out_ready5)
  );

`ifndef CONV_UNPACK_LAST_EN
  assign out_last  = 1'b0;
  assign out_last5 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, val;
    logic [47:0] data;
    logic [1:0]  lanes;
    logic        ordy, last;
    logic        e_ir, e_ov, chk_w;
    logic [15:0] e_ow;
    logic        e_ol;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, fl, val, input logic [47:0] data, input logic [1:0] lanes,
                             input logic ordy, last, e_ir, e_ov, chk_w, input logic [15:0] e_ow,
                             input logic e_ol);
    vec_t r;
    r.rst = rst; r.fl = fl; r.val = val; r.data = data; r.lanes = lanes; r.ordy = ordy; r.last = last;
    r.e_ir = e_ir; r.e_ov = e_ov; r.chk_w = chk_w; r.e_ow = e_ow; r.e_ol = e_ol;
    return r;
  endfunction

  function automatic vec_t idle(input logic e_ir, e_ov, chk_w, input logic [15:0] e_ow, input logic e_ol);
    return v(1'b0, 1'b0, 1'b0, 48'h0, 2'd0, 1'b1, 1'b0, e_ir, e_ov, chk_w, e_ow, e_ol);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [47:0] D1 = 48'h0003_0002_0001;
  localparam logic [47:0] B1 = 48'h000C_000B_000A;
  localparam logic [47:0] B2 = 48'h000F_000E_000D;
  localparam logic [47:0] P  = 48'hFFFF_0002_0001;
  localparam logic [47:0] Z  = 48'h1234_5678_9ABC;

  initial begin
    srst_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; in_data = '0; in_lanes = '0;
    out_ready = 1'b1; in_last = 1'b0;
    flush5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0; in_lanes5 = '0; out_ready5 = 1'b1; in_last5 = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    vecs.push_back(v(1, 0, 1, D1, 3, 1, 0, 0, 0, 1, 16'h0, 0));
    // single full beat
    vecs.push_back(v(0, 0, 1, D1, 3, 1, 0, 1, 0, 0, 16'h0, 0));
    vecs.push_back(idle(0, 1, 1, 16'h1, 0));
    vecs.push_back(idle(0, 1, 1, 16'h2, 0));
    vecs.push_back(idle(1, 1, 1, 16'h3, 0));
    // back-to-back beats
    vecs.push_back(v(0, 0, 1, B1, 3, 1, 0, 1, 0, 0, 16'h0, 0));
    vecs.push_back(v(0, 0, 1, B2, 3, 1, 0, 0, 1, 1, 16'hA, 0));
    vecs.push_back(v(0, 0, 1, B2, 3, 1, 0, 0, 1, 1, 16'hB, 0));
    vecs.push_back(v(0, 0, 1, B2, 3, 1, 0, 1, 1, 1, 16'hC, 0));
    vecs.push_back(idle(0, 1, 1, 16'hD, 0));
    vecs.push_back(idle(0, 1, 1, 16'hE, 0));
    vecs.push_back(idle(1, 1, 1, 16'hF, 0));
    vecs.push_back(idle(1, 0, 0, 16'h0, 0));
    // partial beat, then a zero-lane beat carrying a last marker
    vecs.push_back(v(0, 0, 1, P, 2, 1, 0, 1, 0, 0, 16'h0, 0));
    vecs.push_back(idle(0, 1, 1, 16'h1, 0));
    vecs.push_back(idle(1, 1, 1, 16'h2, 0));
    vecs.push_back(v(0, 0, 1, Z, 0, 1, 1, 1, 0, 0, 16'h0, 0));
    // backpressure, including on the final lane
    vecs.push_back(v(0, 0, 1, D1, 3, 1, 0, 1, 0, 0, 16'h0, 0));
    vecs.push_back(idle(0, 1, 1, 16'h1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 0, 1, D1, 3, 0, 0, 0, 1, 1, 16'h2, 0));
    vecs.push_back(idle(0, 1, 1, 16'h2, 0));
    vecs.push_back(v(0, 0, 1, B1, 3, 0, 0, 0, 1, 1, 16'h3, 1));
    vecs.push_back(idle(1, 1, 1, 16'h3, 1));
    vecs.push_back(idle(1, 0, 0, 16'h0, 0));
    // flush mid-beat
    vecs.push_back(v(0, 0, 1, D1, 3, 1, 0, 1, 0, 0, 16'h0, 0));
    vecs.push_back(idle(0, 1, 1, 16'h1, 0));
    vecs.push_back(v(0, 1, 1, B1, 3, 1, 0, 0, 1, 1, 16'h2, 0));
    vecs.push_back(idle(1, 0, 0, 16'h0, 0));
    vecs.push_back(v(0, 0, 1, B1, 3, 1, 1, 1, 0, 0, 16'h0, 0));
    vecs.push_back(idle(0, 1, 1, 16'hA, 0));
    vecs.push_back(idle(0, 1, 1, 16'hB, 0));
    vecs.push_back(idle(1, 1, 1, 16'hC, 1));
    vecs.push_back(v(0, 1, 1, D1, 3, 1, 0, 0, 0, 0, 16'h0, 0));
    vecs.push_back(idle(1, 0, 0, 16'h0, 0));
    // reset mid-beat
    vecs.push_back(v(0, 0, 1, D1, 3, 1, 0, 1, 0, 0, 16'h0, 0));
    vecs.push_back(idle(0, 1, 1, 16'h1, 0));
    vecs.push_back(v(1, 0, 0, 48'h0, 0, 1, 0, 0, 1, 1, 16'h2, 0));
    vecs.push_back(idle(1, 0, 1, 16'h0, 0));
    vecs.push_back(idle(1, 0, 1, 16'h0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      srst_in = vecs[i].rst; flush_in = vecs[i].fl; in_valid = vecs[i].val; in_data = vecs[i].data;
      in_lanes = vecs[i].lanes; out_ready = vecs[i].ordy; in_last = vecs[i].last;
      #1;
      chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].chk_w) chk($sformatf("row%0d_out_word", i), 32'(out_word), 32'(vecs[i].e_ow));
`ifdef CONV_UNPACK_LAST_EN
      chk($sformatf("row%0d_out_last", i), 32'(out_last), 32'(vecs[i].e_ol));
`endif
    end

    // 5-lane instance: lane count 7 must be clamped to 5
    @(negedge clk);
    in_valid = 1'b0;
    in_valid5 = 1'b1; in_lanes5 = 3'd7;
    in_data5 = {16'h0055, 16'h0044, 16'h0033, 16'h0022, 16'h0011};
    #1;
    chk("clamp_accept_ready", 32'(in_ready5), 32'd1);
    chk("clamp_accept_valid", 32'(out_valid5), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid5 = 1'b0;
      #1;
      chk($sformatf("clamp_w%0d_valid", k), 32'(out_valid5), 32'd1);
      chk($sformatf("clamp_w%0d_word", k), 32'(out_word5), 32'((k + 1) * 'h11));
      chk($sformatf("clamp_w%0d_ready", k), 32'(in_ready5), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1;
    chk("clamp_done_valid", 32'(out_valid5), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
